lcd_bus_scheduler: RTL and testbench

- Owns the HD44780-style character LCD bus (RS, RW, E, DB[7:0]). Runs the power-on init sequence itself.
- Afterwards shares the bus between two requesters (e.g. status-line and score-line writers) with round-robin arbitration.
- Generates all E setup, pulse, hold and busy-wait timing from CLOCK_50.
- Sits between the application logic and the GPIO pins that drive the LCD.

---
 rtl/lcd_bus_scheduler_if.sv | 40 ++++
 rtl/lcd_bus_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_lcd_bus_scheduler.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_scheduler_if.sv
// Requester-side handshake plus the LCD pin bundle of the bus scheduler.
// The scheduler takes the slave view; the application/pin side takes the master view.
interface lcd_bus_scheduler_if;
  logic [1:0]  req;
  logic [1:0]  req_rs;
  logic [15:0] req_data;
  logic [1:0]  ack;
  logic        init_done;
  logic        busy;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_e;
  logic [7:0]  lcd_data;

  modport master (
    output req,
    output req_rs,
    output req_data,
    input  ack,
    input  init_done,
    input  busy,
    input  lcd_rs,
    input  lcd_rw,
    input  lcd_e,
    input  lcd_data
  );

  modport slave (
    input  req,
    input  req_rs,
    input  req_data,
    output ack,
    output init_done,
    output busy,
    output lcd_rs,
    output lcd_rw,
    output lcd_e,
    output lcd_data
  );
endinterface

// File: rtl/lcd_bus_scheduler.sv
// HD44780 character-LCD bus owner: runs the power-on init sequence, then shares the
// write-only bus between two requesters with round-robin arbitration and E timing.
module lcd_bus_scheduler #(
  parameter int unsigned POWERUP_CYC   = 750000,
  parameter int unsigned WAKE_WAIT_CYC = 205000,
  parameter int unsigned E_SETUP_CYC   = 4,
  parameter int unsigned E_HIGH_CYC    = 25,
  parameter int unsigned E_HOLD_CYC    = 2,
  parameter int unsigned CMD_WAIT_CYC  = 2000,
  parameter int unsigned CLR_WAIT_CYC  = 82000
) (
  input logic                CLOCK_50,
  input logic                rst_n,
  lcd_bus_scheduler_if.slave bus
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MaxCyc = max2(max2(max2(POWERUP_CYC, WAKE_WAIT_CYC),
                                             max2(CMD_WAIT_CYC, CLR_WAIT_CYC)),
                                        max2(max2(E_SETUP_CYC, E_HIGH_CYC), E_HOLD_CYC));
  // The counter only ever holds (cycles - 1).
  localparam int unsigned CntW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t PowerupLd = cnt_t'(POWERUP_CYC - 1);
  localparam cnt_t WakeLd    = cnt_t'(WAKE_WAIT_CYC - 1);
  localparam cnt_t SetupLd   = cnt_t'(E_SETUP_CYC - 1);
  localparam cnt_t HighLd    = cnt_t'(E_HIGH_CYC - 1);
  localparam cnt_t HoldLd    = cnt_t'(E_HOLD_CYC - 1);
  localparam cnt_t CmdLd     = cnt_t'(CMD_WAIT_CYC - 1);
  localparam cnt_t ClrLd     = cnt_t'(CLR_WAIT_CYC - 1);
  localparam cnt_t CntOne    = cnt_t'(1);

  typedef enum logic [2:0] {
    StPowerup,
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StWait
  } state_e;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] cmd;
    case (idx)
      3'd0, 3'd1, 3'd2: cmd = 8'h30;
      3'd3:             cmd = 8'h38;
      3'd4:             cmd = 8'h0C;
      3'd5:             cmd = 8'h01;
      3'd6:             cmd = 8'h06;
      default:          cmd = 8'h00;
    endcase
    return cmd;
  endfunction

  function automatic cnt_t init_wait(input logic [2:0] idx);
    cnt_t w;
    case (idx)
      3'd0:    w = WakeLd;
      3'd5:    w = ClrLd;
      default: w = CmdLd;
    endcase
    return w;
  endfunction

  // Clear (0x01) and home (0x02/0x03) are the only slow commands.
  function automatic cnt_t req_wait(input logic rs, input logic [7:0] data);
    return (!rs && (data[7:2] == 6'd0) && (data != 8'd0)) ? ClrLd : CmdLd;
  endfunction

  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  cnt_t       wait_q, wait_d;
  logic [2:0] idx_q, idx_d;
  logic       init_done_q, init_done_d;
  logic       last_q, last_d;
  logic [1:0] owner_q, owner_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       e_q, e_d;
  logic [1:0] ack_q, ack_d;

  logic       start;
  logic       st_rs;
  logic [7:0] st_data;
  cnt_t       st_wait;
  logic [1:0] st_owner;
  logic       gnt;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPowerup;
      cnt_q       <= PowerupLd;
      wait_q      <= '0;
      idx_q       <= 3'd0;
      init_done_q <= 1'b0;
      last_q      <= 1'b1;  // requester 1 "served last" so requester 0 wins first tie
      owner_q     <= 2'b00;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      e_q         <= 1'b0;
      ack_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      e_q         <= e_d;
      ack_q       <= ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    last_d      = last_q;
    owner_d     = owner_q;
    rs_d        = rs_q;
    data_d      = data_q;
    ack_d       = 2'b00;
    start       = 1'b0;
    st_rs       = 1'b0;
    st_data     = init_cmd(idx_q);
    st_wait     = init_wait(idx_q);
    st_owner    = 2'b00;
    gnt         = (bus.req == 2'b11) ? ~last_q : bus.req[1];

    case (state_q)
      StPowerup: begin
        if (cnt_q == '0) begin
          start = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StIdle: begin
        if (!init_done_q) begin
          start = 1'b1;
        end else if (bus.req != 2'b00) begin
          start    = 1'b1;
          st_rs    = bus.req_rs[gnt];
          st_data  = gnt ? bus.req_data[15:8] : bus.req_data[7:0];
          st_wait  = req_wait(st_rs, st_data);
          st_owner = gnt ? 2'b10 : 2'b01;
          last_d   = gnt;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = HighLd;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = HoldLd;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StWait;
          cnt_d   = wait_q;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          ack_d   = owner_q;
          // An empty owner marks an init step.
          if (owner_q == 2'b00) begin
            if (idx_q == 3'd6) begin
              init_done_d = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = StPowerup;
        cnt_d   = PowerupLd;
      end
    endcase

    if (start) begin
      state_d = StSetup;
      cnt_d   = SetupLd;
      rs_d    = st_rs;
      data_d  = st_data;
      wait_d  = st_wait;
      owner_d = st_owner;
    end

    e_d = (state_d == StPulse);
  end

  assign bus.ack       = ack_q;
  assign bus.init_done = init_done_q;
  // Gated by reset so every output reads 0 while rst_n is held low.
  assign bus.busy      = rst_n && (state_q != StIdle);
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_e     = e_q;
  assign bus.lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Bench for lcd_bus_scheduler: directed phases plus random requests, every cycle
// checked against a transfer-level timing model of the LCD bus.
module tb_lcd_bus_scheduler;
  localparam int P   = 10;
  localparam int WK  = 8;
  localparam int S   = 2;
  localparam int H   = 3;
  localparam int HO  = 1;
  localparam int CMD = 4;
  localparam int CLR = 9;

  logic CLOCK_50 = 1'b0;
  logic rst_n    = 1'b0;

  lcd_bus_scheduler_if bus ();

  lcd_bus_scheduler #(
    .POWERUP_CYC  (P),
    .WAKE_WAIT_CYC(WK),
    .E_SETUP_CYC  (S),
    .E_HIGH_CYC   (H),
    .E_HOLD_CYC   (HO),
    .CMD_WAIT_CYC (CMD),
    .CLR_WAIT_CYC (CLR)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] init_rom [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
  int         init_wt  [7] = '{WK, CMD, CMD, CMD, CMD, CLR, CMD};

  // Transfer-level model: one current transfer described by start edge and length.
  int         n;
  bit         in_pu;
  int         cur_t, cur_len, cur_owner;
  logic       cur_rs;
  logic [7:0] cur_data;
  int         init_k, init_done_at, last_srv;

  logic       busy_e, e_e, rs_e, done_e;
  logic [1:0] ack_e;
  logic [7:0] data_e;

  int         want [2];
  bit         rnd;

  function automatic int req_wait(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'd1 && d <= 8'd3) ? CLR : CMD;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n            = 0;
    in_pu        = 1'b1;
    cur_t        = 0;
    cur_len      = 0;
    cur_owner    = -1;
    cur_rs       = 1'b0;
    cur_data     = 8'h00;
    init_k       = 0;
    init_done_at = 1 << 30;
    last_srv     = 1;
  endtask

  task automatic start_xfer(input logic rs, input logic [7:0] d, input int w, input int owner);
    cur_t     = n;
    cur_len   = S + H + HO + w;
    cur_rs    = rs;
    cur_data  = d;
    cur_owner = owner;
  endtask

  task automatic start_init();
    start_xfer(1'b0, init_rom[init_k], init_wt[init_k], -1);
    if (init_k == 6) init_done_at = cur_t + cur_len;
    init_k++;
  endtask

  task automatic model_edge();
    int         g;
    logic [7:0] d;
    if (in_pu) begin
      if (n == P) begin
        in_pu = 1'b0;
        start_init();
      end
    end else if (n - 1 >= cur_t + cur_len) begin
      if (init_k < 7) begin
        start_init();
      end else if (bus.req != 2'b00) begin
        if (bus.req == 2'b11) g = 1 - last_srv;
        else g = bus.req[1] ? 1 : 0;
        last_srv = g;
        d = bus.req_data[8*g +: 8];
        start_xfer(bus.req_rs[g], d, req_wait(bus.req_rs[g], d), g);
      end
    end
  endtask

  task automatic check_all();
    busy_e = in_pu || (n < cur_t + cur_len);
    e_e    = !in_pu && (n >= cur_t + S) && (n < cur_t + S + H);
    ack_e  = 2'b00;
    if (!in_pu && cur_owner >= 0 && n == cur_t + cur_len) ack_e = (cur_owner == 0) ? 2'b01 : 2'b10;
    done_e = (n >= init_done_at);
    rs_e   = cur_rs;
    data_e = cur_data;
    chk("busy", 8'(bus.busy), 8'(busy_e));
    chk("lcd_e", 8'(bus.lcd_e), 8'(e_e));
    chk("ack", 8'(bus.ack), 8'(ack_e));
    chk("init_done", 8'(bus.init_done), 8'(done_e));
    chk("lcd_rs", 8'(bus.lcd_rs), 8'(rs_e));
    chk("lcd_data", bus.lcd_data, data_e);
    chk("lcd_rw", 8'(bus.lcd_rw), 8'h00);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 8'(bus.busy), 8'h00);
    chk({tag, "_lcd_e"}, 8'(bus.lcd_e), 8'h00);
    chk({tag, "_ack"}, 8'(bus.ack), 8'h00);
    chk({tag, "_init_done"}, 8'(bus.init_done), 8'h00);
    chk({tag, "_lcd_rs"}, 8'(bus.lcd_rs), 8'h00);
    chk({tag, "_lcd_data"}, bus.lcd_data, 8'h00);
    chk({tag, "_lcd_rw"}, 8'(bus.lcd_rw), 8'h00);
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (ack_e[i] && want[i] > 0) want[i]--;
      if (rnd && want[i] == 0 && $urandom_range(3) == 0) begin
        want[i]                = 1;
        bus.req_rs[i]          = 1'($urandom_range(1));
        bus.req_data[8*i +: 8] = ($urandom_range(2) == 0) ? 8'($urandom_range(3))
                                                           : 8'($urandom_range(255));
      end
      bus.req[i] = (want[i] > 0);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    n++;
    model_edge();
    #1;
    check_all();
    drive();
  endtask

  task automatic run_until_idle(input string tag, input int bound);
    int  i;
    logic done;
    i = 0;
    while (i < bound && (want[0] != 0 || want[1] != 0 || busy_e || !done_e)) begin
      step();
      i++;
    end
    done = (want[0] == 0 && want[1] == 0 && !busy_e && done_e);
    chk({tag, "_timeout"}, 8'(done), 8'h01);
  endtask

  task automatic run_until_pulse(input string tag, input int bound);
    int i;
    i = 0;
    while (i < bound && !(e_e && cur_owner >= 0)) begin
      step();
      i++;
    end
    chk({tag, "_timeout"}, 8'(e_e), 8'h01);
  endtask

  initial begin
    bus.req      = 2'b00;
    bus.req_rs   = 2'b00;
    bus.req_data = 16'h0000;
    want[0]      = 0;
    want[1]      = 0;
    rnd          = 1'b0;
    model_reset();
    busy_e       = 1'b1;
    done_e       = 1'b0;
    ack_e        = 2'b00;
    e_e          = 1'b0;

    // Held in reset: everything reads zero.
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk_zero("reset");
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    model_reset();

    // Init runs alone for a while, then requester 0 asks early and must wait.
    repeat (20) step();
    bus.req_rs[0]     = 1'b1;
    bus.req_data[7:0] = 8'h41;
    want[0]           = 1;
    bus.req[0]        = 1'b1;
    run_until_idle("early_req", 400);

    // Both requesters hold req: grants alternate.
    bus.req_rs         = 2'b11;
    bus.req_data       = 16'h55AA;
    want[0]            = 2;
    want[1]            = 2;
    bus.req            = 2'b11;
    run_until_idle("round_robin", 200);

    // Slow clear command, then a normal command.
    bus.req_rs[1]      = 1'b0;
    bus.req_data[15:8] = 8'h01;
    want[1]            = 1;
    bus.req[1]         = 1'b1;
    run_until_idle("clear", 100);
    bus.req_data[15:8] = 8'h80;
    want[1]            = 1;
    bus.req[1]         = 1'b1;
    run_until_idle("cmd80", 100);

    // Data change and req drop mid-pulse must not disturb the transfer.
    bus.req_rs[0]     = 1'b1;
    bus.req_data[7:0] = 8'h41;
    want[0]           = 1;
    bus.req[0]        = 1'b1;
    run_until_pulse("mid_pulse", 50);
    bus.req_data[7:0] = 8'hFF;
    want[0]           = 0;
    bus.req[0]        = 1'b0;
    repeat (20) step();

    // Random traffic.
    rnd = 1'b1;
    repeat (400) step();
    rnd = 1'b0;
    run_until_idle("rand_drain", 200);

    // Reset while E is high, then the whole init sequence again.
    bus.req_rs[0]     = 1'b0;
    bus.req_data[7:0] = 8'h38;
    want[0]           = 1;
    bus.req[0]        = 1'b1;
    run_until_pulse("pre_reset", 50);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk_zero("rst_hold");
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    model_reset();
    busy_e = 1'b1;
    done_e = 1'b0;
    ack_e  = 2'b00;
    e_e    = 1'b0;
    run_until_idle("reinit", 400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
